// File: rtl/mips_pkg.sv
// Shared MIPS-I decode constants: opcodes, R-type functs, ALU f-codes and the ID/EX register layout.
// Also used by alu32 and the EX stage, so the f-code values must not move.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;
    localparam logic [3:0] ALU_NOR  = 4'hA;
    localparam logic [3:0] ALU_SLLV = 4'hB;
    localparam logic [3:0] ALU_SRLV = 4'hC;
    localparam logic [3:0] ALU_SRAV = 4'hD;
    localparam logic [3:0] ALU_LUI  = 4'hE;

    typedef struct packed {
        logic        valid;
        logic [3:0]  alu_f;
        logic [4:0]  shamt;
        logic        alu_src_imm;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        branch_ne;
        logic        illegal;
    } idex_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// Pure combinational MIPS-I decoder: instruction word -> ALU f-code, operand select, immediate and
// write-back/memory/branch controls. Illegal encodings decode as ADD with no side effects.
module mips_alu_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  alu_f,
    output logic        alu_src_imm,
    output logic [31:0] imm,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  shamt,
    output logic [4:0]  dst_reg,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        branch_ne,
    output logic        uses_rt,
    output logic        illegal
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic        writes;

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign funct = instr[5:0];
    assign imm16 = instr[15:0];

    always_comb begin
        alu_f       = ALU_ADD;
        alu_src_imm = 1'b0;
        imm         = '0;
        dst_reg     = '0;
        writes      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        branch      = 1'b0;
        branch_ne   = 1'b0;
        uses_rt     = 1'b0;
        illegal     = 1'b0;
        case (op)
            OP_RTYPE: begin
                dst_reg = rd;
                writes  = 1'b1;
                uses_rt = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_f = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_f = ALU_SUB;
                    FN_AND:          alu_f = ALU_AND;
                    FN_OR:           alu_f = ALU_OR;
                    FN_XOR:          alu_f = ALU_XOR;
                    FN_NOR:          alu_f = ALU_NOR;
                    FN_SLT:          alu_f = ALU_SLT;
                    FN_SLTU:         alu_f = ALU_SLTU;
                    FN_SLL:          alu_f = ALU_SLL;
                    FN_SRL:          alu_f = ALU_SRL;
                    FN_SRA:          alu_f = ALU_SRA;
                    FN_SLLV:         alu_f = ALU_SLLV;
                    FN_SRLV:         alu_f = ALU_SRLV;
                    FN_SRAV:         alu_f = ALU_SRAV;
                    FN_JR: begin
                        writes  = 1'b0;
                        uses_rt = 1'b0;
                    end
                    default: begin
                        illegal = 1'b1;
                        writes  = 1'b0;
                        uses_rt = 1'b0;
                        dst_reg = '0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dst_reg     = rt;
                alu_src_imm = 1'b1;
                writes      = 1'b1;
                imm         = sext16(imm16);
                case (op)
                    OP_SLTI:  alu_f = ALU_SLT;
                    OP_SLTIU: alu_f = ALU_SLTU;
                    OP_LW:    mem_read = 1'b1;
                    OP_ANDI: begin alu_f = ALU_AND; imm = zext16(imm16); end
                    OP_ORI:  begin alu_f = ALU_OR;  imm = zext16(imm16); end
                    OP_XORI: begin alu_f = ALU_XOR; imm = zext16(imm16); end
                    OP_LUI:  begin alu_f = ALU_LUI; imm = zext16(imm16); end
                    default: alu_f = ALU_ADD;
                endcase
            end
            OP_SW: begin
                dst_reg     = rt;
                alu_src_imm = 1'b1;
                imm         = sext16(imm16);
                mem_write   = 1'b1;
                uses_rt     = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dst_reg   = rt;
                alu_f     = ALU_SUB;
                imm       = sext16(imm16);
                branch    = 1'b1;
                branch_ne = (op == OP_BNE);
                uses_rt   = 1'b1;
            end
            OP_J, OP_JAL: alu_f = ALU_ADD;
            default: illegal = 1'b1;
        endcase
        // Writes to $0 are architecturally discarded; suppress them here so EX never sees them.
        reg_write = writes & (dst_reg != '0);
    end

endmodule

// File: rtl/mips_id_ex_ctrl.sv
// ID/EX control stage: decodes the IF/ID instruction, detects load-use hazards and holds the
// decoded bundle in the ID/EX register with reset > flush > hold > load > bubble priority.
module mips_id_ex_ctrl
    import mips_pkg::*;
#(
    parameter bit NOP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_instr,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [3:0]  ex_alu_f,
    output logic [4:0]  ex_shamt,
    output logic        ex_alu_src_imm,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_dst_reg,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic        ex_branch_ne,
    output logic        ex_illegal
);

    idex_t idex_q;
    idex_t idex_d;
    idex_t dec;
    logic  dec_uses_rt;
    logic  load_use;

    mips_alu_decode u_decode (
        .instr       (id_instr),
        .alu_f       (dec.alu_f),
        .alu_src_imm (dec.alu_src_imm),
        .imm         (dec.imm),
        .rs          (dec.rs),
        .rt          (dec.rt),
        .shamt       (dec.shamt),
        .dst_reg     (dec.dst_reg),
        .reg_write   (dec.reg_write),
        .mem_read    (dec.mem_read),
        .mem_write   (dec.mem_write),
        .branch      (dec.branch),
        .branch_ne   (dec.branch_ne),
        .uses_rt     (dec_uses_rt),
        .illegal     (dec.illegal)
    );

    // An illegal instruction becomes a bubble when NOP_ON_ILLEGAL, otherwise it issues as a write-less ADD.
    assign dec.valid = ~(dec.illegal & NOP_ON_ILLEGAL);

    assign load_use = idex_q.valid & idex_q.mem_read & (idex_q.dst_reg != '0) &
                      ((dec.rs == idex_q.dst_reg) | (dec_uses_rt & (dec.rt == idex_q.dst_reg)));

    assign id_ready = (~idex_q.valid | ex_ready) & ~load_use & ~flush;

    always_comb begin
        idex_d = '0;
        if (!flush) begin
            if (idex_q.valid && !ex_ready) begin
                // Hold keeps the bundle but the illegal flag must stay a single-cycle pulse.
                idex_d         = idex_q;
                idex_d.illegal = 1'b0;
            end else if (id_valid && id_ready) begin
                idex_d = dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign ex_valid       = idex_q.valid;
    assign ex_alu_f       = idex_q.alu_f;
    assign ex_shamt       = idex_q.shamt;
    assign ex_alu_src_imm = idex_q.alu_src_imm;
    assign ex_imm         = idex_q.imm;
    assign ex_rs          = idex_q.rs;
    assign ex_rt          = idex_q.rt;
    assign ex_dst_reg     = idex_q.dst_reg;
    assign ex_reg_write   = idex_q.reg_write;
    assign ex_mem_read    = idex_q.mem_read;
    assign ex_mem_write   = idex_q.mem_write;
    assign ex_branch      = idex_q.branch;
    assign ex_branch_ne   = idex_q.branch_ne;
    assign ex_illegal     = idex_q.illegal;

endmodule

// File: tb/tb_mips_id_ex_ctrl.sv
// Self-checking bench for mips_id_ex_ctrl: directed vector table, hand-written pipeline sequences
// and a randomized stream compared against a table-based behavioural model of the stage.
module tb_mips_id_ex_ctrl;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [3:0]  ex_alu_f;
    logic [4:0]  ex_shamt;
    logic        ex_alu_src_imm;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_dst_reg;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_branch_ne;
    logic        ex_illegal;

    mips_id_ex_ctrl #(.NOP_ON_ILLEGAL(1'b1)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .flush          (flush),
        .ex_ready       (ex_ready),
        .ex_valid       (ex_valid),
        .ex_alu_f       (ex_alu_f),
        .ex_shamt       (ex_shamt),
        .ex_alu_src_imm (ex_alu_src_imm),
        .ex_imm         (ex_imm),
        .ex_rs          (ex_rs),
        .ex_rt          (ex_rt),
        .ex_dst_reg     (ex_dst_reg),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_branch      (ex_branch),
        .ex_branch_ne   (ex_branch_ne),
        .ex_illegal     (ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference decode tables: R-type funct -> f, and opcode -> (f, extension, kind).
    // ext: 0 none, 1 sign, 2 zero.  kind: 0 alu write, 1 load, 2 store, 3 beq, 4 bne, 5 jump.
    logic [5:0] R_FN [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                              6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
    logic [3:0] R_F  [17] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'h8,
                              4'h9, 4'h5, 4'h6, 4'h7, 4'hB, 4'hC, 4'hD, 4'h0};
    logic [5:0] I_OP [14] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                              6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [3:0] I_F  [14] = '{4'h0, 4'h0, 4'h8, 4'h9, 4'h2, 4'h3, 4'h4, 4'hE,
                              4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0};
    int         I_EXT[14] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0};
    int         I_KND[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 5};
    logic [5:0] OPS  [15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                              6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

    typedef struct {
        logic [3:0]  f;
        logic        simm;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        bne;
        logic        ill;
        logic        usert;
    } dec_m_t;

    function automatic dec_m_t ref_decode(input logic [31:0] ins);
        dec_m_t e;
        logic [5:0] op;
        logic [4:0] rt;
        op = ins[31:26];
        rt = ins[20:16];
        e = '{f:4'h0, simm:1'b0, imm:32'h0, dst:5'h0, rw:1'b0, mr:1'b0, mw:1'b0,
              br:1'b0, bne:1'b0, ill:1'b1, usert:1'b0};
        if (op == 6'h00) begin
            for (int i = 0; i < 17; i++) begin
                if (R_FN[i] == ins[5:0]) begin
                    e.f   = R_F[i];
                    e.ill = 1'b0;
                end
            end
            if (!e.ill && ins[5:0] != 6'h08) begin
                e.dst   = ins[15:11];
                e.rw    = (ins[15:11] != 5'd0);
                e.usert = 1'b1;
            end
        end else begin
            for (int i = 0; i < 14; i++) begin
                if (I_OP[i] == op) begin
                    e.ill = 1'b0;
                    e.f   = I_F[i];
                    if (I_EXT[i] == 1) e.imm = {{16{ins[15]}}, ins[15:0]};
                    if (I_EXT[i] == 2) e.imm = {16'h0000, ins[15:0]};
                    if (I_KND[i] <= 2) e.simm = 1'b1;
                    if (I_KND[i] <= 1) begin
                        e.dst = rt;
                        e.rw  = (rt != 5'd0);
                    end
                    e.mr  = (I_KND[i] == 1);
                    e.mw  = (I_KND[i] == 2);
                    e.br  = (I_KND[i] == 3) || (I_KND[i] == 4);
                    e.bne = (I_KND[i] == 4);
                    e.usert = (I_KND[i] >= 2) && (I_KND[i] <= 4);
                end
            end
        end
        return e;
    endfunction

    // Behavioural model of the ID/EX register contents.
    logic        m_valid = 1'b0;
    logic        m_ill   = 1'b0;
    logic        m_zero  = 1'b1;
    dec_m_t      m_e;
    logic [31:0] m_ins   = '0;
    logic        rdy_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] ins, input logic er,
                         input logic fl, input logic rst);
        dec_m_t d;
        logic   lu;
        logic   rdy;
        id_valid = v;
        id_instr = ins;
        ex_ready = er;
        flush    = fl;
        reset    = rst;
        #1;
        d   = ref_decode(ins);
        lu  = m_valid && m_e.mr && (m_e.dst != 5'd0) &&
              ((ins[25:21] == m_e.dst) || (d.usert && ins[20:16] == m_e.dst));
        rdy = (!m_valid || er) && !lu && !fl;
        rdy_seen = id_ready;
        if (!rst) chk("id_ready", {31'b0, id_ready}, {31'b0, rdy});
        if (rst || fl) begin
            m_valid = 1'b0; m_ill = 1'b0; m_zero = 1'b1;
        end else if (m_valid && !er) begin
            m_ill = 1'b0;
        end else if (v && rdy) begin
            m_e = d; m_ins = ins; m_ill = d.ill; m_valid = !d.ill; m_zero = 1'b0;
        end else begin
            m_valid = 1'b0; m_ill = 1'b0; m_zero = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
        chk("ex_illegal", {31'b0, ex_illegal}, {31'b0, m_ill});
        if (m_valid) begin
            chk("ex_alu_f", {28'b0, ex_alu_f}, {28'b0, m_e.f});
            chk("ex_ctrl", {26'b0, ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_branch && ex_branch_ne},
                {26'b0, m_e.simm, m_e.rw, m_e.mr, m_e.mw, m_e.br, m_e.br && m_e.bne});
            chk("ex_fields", {17'b0, ex_rs, ex_rt, ex_shamt}, {17'b0, m_ins[25:21], m_ins[20:16], m_ins[10:6]});
            if (m_e.rw) chk("ex_dst_reg", {27'b0, ex_dst_reg}, {27'b0, m_e.dst});
            if (m_e.simm || m_e.br) chk("ex_imm", ex_imm, m_e.imm);
        end
        if (m_zero) chk("zero_fields", {ex_imm[27:0], ex_alu_f} | {27'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_imm[31]}, 32'h0);
    endtask

    typedef struct {
        logic [31:0] ins;
        logic        v;
        logic        ill;
        logic [3:0]  f;
        logic        simm;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
    } vec_t;

    vec_t tbl [14];

    localparam logic [31:0] I_SUB   = 32'h014B4822;
    localparam logic [31:0] I_LW    = 32'h8D280000;
    localparam logic [31:0] I_ADD8  = 32'h01085020;
    localparam logic [31:0] I_LUI   = 32'h3C08ABCD;
    localparam logic [31:0] I_ILL   = 32'hFC000000;

    initial begin
        tbl[0]  = '{32'h014B4822, 1, 0, 4'h1, 0, 32'h0,        5'd9,  1, 0, 0, 0};
        tbl[1]  = '{32'h3C08ABCD, 1, 0, 4'hE, 1, 32'h0000ABCD, 5'd8,  1, 0, 0, 0};
        tbl[2]  = '{32'h3108FFFF, 1, 0, 4'h2, 1, 32'h0000FFFF, 5'd8,  1, 0, 0, 0};
        tbl[3]  = '{32'h2128FFFC, 1, 0, 4'h0, 1, 32'hFFFFFFFC, 5'd8,  1, 0, 0, 0};
        tbl[4]  = '{32'h8D280000, 1, 0, 4'h0, 1, 32'h0,        5'd8,  1, 1, 0, 0};
        tbl[5]  = '{32'hAD280004, 1, 0, 4'h0, 1, 32'h4,        5'd0,  0, 0, 1, 0};
        tbl[6]  = '{32'h00000000, 1, 0, 4'h5, 0, 32'h0,        5'd0,  0, 0, 0, 0};
        tbl[7]  = '{32'hFC000000, 0, 1, 4'h0, 0, 32'h0,        5'd0,  0, 0, 0, 0};
        tbl[8]  = '{32'h0109502A, 1, 0, 4'h8, 0, 32'h0,        5'd10, 1, 0, 0, 0};
        tbl[9]  = '{32'h11090010, 1, 0, 4'h1, 0, 32'h00000010, 5'd0,  0, 0, 0, 1};
        tbl[10] = '{32'h2D288000, 1, 0, 4'h9, 1, 32'hFFFF8000, 5'd8,  1, 0, 0, 0};
        tbl[11] = '{32'h01200008, 1, 0, 4'h0, 0, 32'h0,        5'd0,  0, 0, 0, 0};
        tbl[12] = '{32'h00094083, 1, 0, 4'h7, 0, 32'h0,        5'd8,  1, 0, 0, 0};
        tbl[13] = '{32'h0000003F, 0, 1, 4'h0, 0, 32'h0,        5'd0,  0, 0, 0, 0};

        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("reset_valid", {31'b0, ex_valid}, 32'h0);

        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, tbl[i].ins, 1'b1, 1'b0, 1'b0);
            chk("tbl_valid", {31'b0, ex_valid}, {31'b0, tbl[i].v});
            chk("tbl_illegal", {31'b0, ex_illegal}, {31'b0, tbl[i].ill});
            if (tbl[i].v) begin
                chk("tbl_f", {28'b0, ex_alu_f}, {28'b0, tbl[i].f});
                chk("tbl_ctrl", {27'b0, ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch},
                    {27'b0, tbl[i].simm, tbl[i].rw, tbl[i].mr, tbl[i].mw, tbl[i].br});
                chk("tbl_shamt", {27'b0, ex_shamt}, {27'b0, tbl[i].ins[10:6]});
                if (tbl[i].rw) chk("tbl_dst", {27'b0, ex_dst_reg}, {27'b0, tbl[i].dst});
                if (tbl[i].simm || tbl[i].br) chk("tbl_imm", ex_imm, tbl[i].imm);
            end
            cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        end

        // Reset in the middle of a stream.
        cycle(1'b1, I_SUB, 1'b1, 1'b0, 1'b0);
        chk("pre_reset_f", {28'b0, ex_alu_f}, 32'h1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("rst_valid", {31'b0, ex_valid}, 32'h0);
        chk("rst_f", {28'b0, ex_alu_f}, 32'h0);
        chk("rst_rw", {31'b0, ex_reg_write}, 32'h0);

        // Load-use: one stall cycle, one bubble, then the dependent add issues.
        cycle(1'b1, I_LW, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, I_ADD8, 1'b1, 1'b0, 1'b0);
        chk("lu_ready", {31'b0, rdy_seen}, 32'h0);
        chk("lu_bubble", {31'b0, ex_valid}, 32'h0);
        cycle(1'b1, I_ADD8, 1'b1, 1'b0, 1'b0);
        chk("lu_ready2", {31'b0, rdy_seen}, 32'h1);
        chk("lu_issue", {31'b0, ex_valid}, 32'h1);
        chk("lu_dst", {27'b0, ex_dst_reg}, 32'd10);

        // EX back-pressure for three cycles, then flush while holding.
        cycle(1'b1, I_SUB, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, I_LUI, 1'b0, 1'b0, 1'b0);
            chk("hold_ready", {31'b0, rdy_seen}, 32'h0);
            chk("hold_valid", {31'b0, ex_valid}, 32'h1);
            chk("hold_f", {28'b0, ex_alu_f}, 32'h1);
            chk("hold_dst", {27'b0, ex_dst_reg}, 32'd9);
        end
        cycle(1'b1, I_LUI, 1'b0, 1'b1, 1'b0);
        chk("hold_flush", {31'b0, ex_valid}, 32'h0);
        cycle(1'b1, I_LUI, 1'b1, 1'b1, 1'b0);
        chk("flush_mask_ready", {31'b0, rdy_seen}, 32'h0);
        chk("flush_no_accept", {31'b0, ex_valid}, 32'h0);

        // Illegal flag is a single-cycle pulse.
        cycle(1'b1, I_ILL, 1'b1, 1'b0, 1'b0);
        chk("ill_pulse", {30'b0, ex_illegal, ex_valid}, 32'h2);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("ill_clear", {31'b0, ex_illegal}, 32'h0);

        for (int n = 0; n < 800; n++) begin
            logic [31:0] ins;
            int          k;
            k   = $urandom_range(0, 15);
            ins = $urandom;
            if (k < 15) ins[31:26] = OPS[k];
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            ins[15:11] = 5'($urandom_range(0, 3));
            if (ins[31:26] == 6'h00 && $urandom_range(0, 7) != 0) ins[5:0] = R_FN[$urandom_range(0, 16)];
            cycle($urandom_range(0, 9) < 8, ins, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
